// File: rtl/lc3_seq_ctrl_if.sv
// LC3 single-port memory handshake bundle (request/ready).
// master: req, we, addr, wdata out; rdata, ready in. slave: mirror.
interface lc3_seq_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic [15:0]       rdata;
    logic              ready;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/lc3_seq_ctrl.sv
// LC3 multi-cycle sequencer: owns PC, IR and NZP, fetches over the
// mem handshake, issues LD/ST accesses and register-file writes.
// Ports: clk, rst (sync, active-high); mem (master handshake);
// o_pc/o_ir/o_n/o_z/o_p state; i_next_pc/i_alu_result/i_st_data from
// the datapath; o_reg_we/o_reg_waddr/o_reg_wdata write port; o_halted.
// Optional: define LC3_RETIRE_CNT_EN to add o_retired[31:0].
module lc3_seq_ctrl #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h3000
) (
    input  logic              clk,
    input  logic              rst,
    lc3_seq_ctrl_if.master    mem,
    output logic [ADDR_W-1:0] o_pc,
    output logic [15:0]       o_ir,
    output logic              o_n,
    output logic              o_z,
    output logic              o_p,
    input  logic [ADDR_W-1:0] i_next_pc,
    input  logic [15:0]       i_alu_result,
    input  logic [15:0]       i_st_data,
    output logic              o_reg_we,
    output logic [2:0]        o_reg_waddr,
    output logic [15:0]       o_reg_wdata,
    output logic              o_halted
`ifdef LC3_RETIRE_CNT_EN
    ,
    output logic [31:0]       o_retired
`endif
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [2:0]        r_nzp;
    logic [15:0]       r_wdata;

    logic [3:0]        w_op;
    logic              w_is_alu;
    logic              w_is_ld;
    logic              w_is_st;
    logic              w_is_halt;
    logic              w_req;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic              w_rwe;
    logic [2:0]        w_nzp_new;

    assign w_op      = r_ir[15:12];
    assign w_is_alu  = (w_op == 4'b0001) || (w_op == 4'b0101) ||
                       (w_op == 4'b1001);
    assign w_is_ld   = (w_op == 4'b0010);
    assign w_is_st   = (w_op == 4'b0011);
    assign w_is_halt = (w_op == 4'b1111);

    assign w_nzp_new = r_wdata[15]       ? 3'b100 :
                       (r_wdata == 16'h0) ? 3'b010 : 3'b001;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        w_we   = 1'b0;
        w_addr = r_pc;
        w_rwe  = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                if (mem.ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    w_is_alu:           w_next = S_EXEC;
                    w_is_ld || w_is_st: w_next = S_MEM;
                    w_is_halt:          w_next = S_HALT;
                    default:            w_next = S_WB;
                endcase
            end
            S_EXEC: begin
                w_next = S_WB;
            end
            S_MEM: begin
                w_req  = 1'b1;
                w_we   = w_is_st;
                w_addr = {{(ADDR_W-9){1'b0}}, r_ir[8:0]};
                if (mem.ready) begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                w_rwe  = w_is_alu || w_is_ld;
                w_next = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Datapath registers; rdata is only consumed in FETCH/MEM so a stray
    // ready in any other state has no effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_ir    <= 16'h0;
            r_nzp   <= 3'b010;
            r_wdata <= 16'h0;
        end else begin
            if (r_state == S_FETCH && mem.ready) begin
                r_ir <= mem.rdata;
            end
            if (r_state == S_EXEC) begin
                r_wdata <= i_alu_result;
            end
            if (r_state == S_MEM && mem.ready && w_is_ld) begin
                r_wdata <= mem.rdata;
            end
            if (r_state == S_WB) begin
                r_pc <= i_next_pc;
                if (w_rwe) begin
                    r_nzp <= w_nzp_new;
                end
            end
        end
    end

`ifdef LC3_RETIRE_CNT_EN
    logic [31:0] r_retired;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= 32'h0;
        end else if (r_state == S_WB) begin
            r_retired <= r_retired + 32'h1;
        end
    end

    assign o_retired = r_retired;
`endif

    // Strobes are masked by rst so a request in flight is dropped in the
    // reset cycle itself rather than one cycle later.
    assign mem.req     = w_req & ~rst;
    assign mem.we      = w_we & ~rst;
    assign mem.addr    = w_addr;
    assign mem.wdata   = i_st_data;

    assign o_pc        = r_pc;
    assign o_ir        = r_ir;
    assign o_n         = r_nzp[2];
    assign o_z         = r_nzp[1];
    assign o_p         = r_nzp[0];
    assign o_reg_we    = w_rwe & ~rst;
    assign o_reg_waddr = r_ir[11:9];
    assign o_reg_wdata = r_wdata;
    assign o_halted    = (r_state == S_HALT) & ~rst;

endmodule
